// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer with stall/flush/bubble controls, EX forwarding selects
// and a data-memory wait FSM with timeout. Define HAZARD_FWD_EN to enable forwarding; otherwise full RAW interlock.
module hazard_ctrl #(
  parameter int WAIT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_mem_op,
  input  logic       ex_redirect,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       stall_ex,
  output logic       bubble_wb,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;
  localparam logic [WAIT_W-1:0] CNT_MAX = {WAIT_W{1'b1}};

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_cnt;

  logic       r_ex_v, r_ex_rw, r_ex_mo;
  logic [4:0] r_ex_rd;
  logic       r_mem_v, r_mem_rw, r_mem_mo;
  logic [4:0] r_mem_rd;
  logic       r_wb_v, r_wb_rw;
  logic [4:0] r_wb_rd;

  logic [2:0] w_stg_v, w_stg_rw, w_hit_id;
  logic [4:0] w_stg_rd [3];
  logic       w_mem_busy, w_mw, w_lu, w_redir, w_lu_eff, w_ex_load;
  logic [1:0] w_fwd_a, w_fwd_b;

  // Stage index 0 = EX, 1 = MEM, 2 = WB.
  assign w_stg_v     = {r_wb_v, r_mem_v, r_ex_v};
  assign w_stg_rw    = {r_wb_rw, r_mem_rw, r_ex_rw};
  assign w_stg_rd[0] = r_ex_rd;
  assign w_stg_rd[1] = r_mem_rd;
  assign w_stg_rd[2] = r_wb_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign w_hit_id[gi] = w_stg_v[gi] & w_stg_rw[gi] &
        ((id_use_rs1 & (w_stg_rd[gi] == id_rs1) & (id_rs1 != 5'd0)) |
         (id_use_rs2 & (w_stg_rd[gi] == id_rs2) & (id_rs2 != 5'd0)));
    end
  endgenerate

  assign w_mem_busy = r_mem_v & r_mem_mo;

  // The cycle dmem_ready arrives in WAIT is already a free-running cycle.
  always_comb begin
    w_mw = 1'b1;
    case (r_state)
      S_RUN:   w_mw = w_mem_busy & ~dmem_ready;
      S_WAIT:  w_mw = ~dmem_ready;
      default: w_mw = 1'b1;
    endcase
  end

`ifdef HAZARD_FWD_EN
  logic       r_ex_ld, r_ex_u1, r_ex_u2;
  logic [4:0] r_ex_rs1, r_ex_rs2;
  logic       w_unused_hits;

  assign w_unused_hits = |w_hit_id[2:1];
  assign w_lu          = id_valid & r_ex_ld & w_hit_id[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_ld  <= 1'b0;
      r_ex_u1  <= 1'b0;
      r_ex_u2  <= 1'b0;
      r_ex_rs1 <= 5'd0;
      r_ex_rs2 <= 5'd0;
    end else if (w_ex_load) begin
      r_ex_ld  <= id_mem_read;
      r_ex_u1  <= id_use_rs1;
      r_ex_u2  <= id_use_rs2;
      r_ex_rs1 <= id_rs1;
      r_ex_rs2 <= id_rs2;
    end
  end

  // Only a valid EX instruction that actually reads the operand gets a bypass.
  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (r_ex_v & r_ex_u1 & (r_ex_rs1 != 5'd0)) begin
      if (r_mem_v & r_mem_rw & (r_mem_rd == r_ex_rs1))   w_fwd_a = 2'd1;
      else if (r_wb_v & r_wb_rw & (r_wb_rd == r_ex_rs1)) w_fwd_a = 2'd2;
    end
    if (r_ex_v & r_ex_u2 & (r_ex_rs2 != 5'd0)) begin
      if (r_mem_v & r_mem_rw & (r_mem_rd == r_ex_rs2))   w_fwd_b = 2'd1;
      else if (r_wb_v & r_wb_rw & (r_wb_rd == r_ex_rs2)) w_fwd_b = 2'd2;
    end
  end
`else
  logic w_unused_nofwd;

  assign w_unused_nofwd = id_mem_read;
  assign w_lu           = id_valid & (|w_hit_id);
  assign w_fwd_a        = 2'd0;
  assign w_fwd_b        = 2'd0;
`endif

  assign w_redir   = ex_redirect & ~w_mw;
  assign w_lu_eff  = w_lu & ~w_mw & ~w_redir;
  assign w_ex_load = ~w_mw & ~w_redir & ~w_lu_eff;

  assign stall_if    = ~rst & (w_mw | w_lu_eff);
  assign stall_id    = ~rst & (w_mw | w_lu_eff);
  assign flush_id    = ~rst & w_redir;
  assign bubble_ex   = ~rst & (w_redir | w_lu_eff);
  assign stall_ex    = ~rst & w_mw;
  assign bubble_wb   = ~rst & w_mw;
  assign fwd_a       = rst ? 2'd0 : w_fwd_a;
  assign fwd_b       = rst ? 2'd0 : w_fwd_b;
  assign mem_timeout = ~rst & (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v   <= 1'b0;
      r_ex_rw  <= 1'b0;
      r_ex_mo  <= 1'b0;
      r_ex_rd  <= 5'd0;
      r_mem_v  <= 1'b0;
      r_mem_rw <= 1'b0;
      r_mem_mo <= 1'b0;
      r_mem_rd <= 5'd0;
      r_wb_v   <= 1'b0;
      r_wb_rw  <= 1'b0;
      r_wb_rd  <= 5'd0;
    end else if (w_mw) begin
      r_wb_v <= 1'b0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_rw  <= r_mem_rw;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_rw <= r_ex_rw;
      r_mem_mo <= r_ex_mo;
      r_mem_rd <= r_ex_rd;
      r_ex_v   <= w_ex_load & id_valid;
      r_ex_rw  <= id_reg_write;
      r_ex_mo  <= id_mem_op;
      r_ex_rd  <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_busy & ~dmem_ready) begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_W'(1);
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

endmodule
